// File: rtl/instr_fetch_decode.sv
// Fetch/decode front end: fetches 16-bit words over a req/ack port,
// splits them into register fields and strobes each one to execute.
module instr_fetch_decode #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   imem_ack,
  input  logic                   stall,
  output logic [3:0]             opcode,
  output logic [3:0]             rd,
  output logic [3:0]             rs1,
  output logic [3:0]             rs2,
  output logic                   instr_valid,
  output logic [PC_WIDTH-1:0]    pc,
  output logic                   halted
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [INSTR_WIDTH-1:0] ir;
  logic                   load;
  logic                   is_halt;

  assign load    = (state == S_FETCH) && imem_ack;
  assign is_halt = (ir[15:12] == 4'hF);

  assign opcode = ir[15:12];
  assign rd     = ir[11:8];
  assign rs1    = ir[7:4];
  assign rs2    = ir[3:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // IR and pc only move on an acknowledged fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir <= '0;
      pc <= '0;
    end else if (load) begin
      ir <= imem_rdata;
      pc <= pc + PC_WIDTH'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (!stall) begin
          state_nxt = is_halt ? S_HALT : S_FETCH;
        end
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    imem_addr   = '0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    unique case (1'b1)
      (state == S_FETCH): begin
        imem_req  = 1'b1;
        imem_addr = pc;
      end
      (state == S_EXEC): begin
        instr_valid = !stall && !is_halt;
      end
      (state == S_HALT): begin
        halted = 1'b1;
      end
      default: begin
        halted = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed bench for instr_fetch_decode: one task per scenario,
// plus a PC_WIDTH=2 instance to exercise address wrap.
module tb_instr_fetch_decode;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ack;
  logic        stall;
  logic [3:0]  opcode;
  logic [3:0]  rd;
  logic [3:0]  rs1;
  logic [3:0]  rs2;
  logic        instr_valid;
  logic [7:0]  pc;
  logic        halted;

  logic        start2;
  logic        req2;
  logic [1:0]  addr2;
  logic [15:0] rdata2;
  logic        ack2;
  logic [3:0]  op2;
  logic [3:0]  rd2;
  logic [3:0]  rs1_2;
  logic [3:0]  rs2_2;
  logic        iv2;
  logic [1:0]  pc2;
  logic        halted2;

  int vecs;
  int errs;

  instr_fetch_decode dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .stall      (stall),
    .opcode     (opcode),
    .rd         (rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .instr_valid(instr_valid),
    .pc         (pc),
    .halted     (halted)
  );

  instr_fetch_decode #(.PC_WIDTH(2)) dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start2),
    .imem_req   (req2),
    .imem_addr  (addr2),
    .imem_rdata (rdata2),
    .imem_ack   (ack2),
    .stall      (1'b0),
    .opcode     (op2),
    .rd         (rd2),
    .rs1        (rs1_2),
    .rs2        (rs2_2),
    .instr_valid(iv2),
    .pc         (pc2),
    .halted     (halted2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n      = 1'b0;
    start      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 16'h0;
    stall      = 1'b0;
    start2     = 1'b0;
    ack2       = 1'b0;
    rdata2     = 16'h0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    #1;
    vecs++;
    if ({imem_req, imem_addr, instr_valid, halted, pc} !== 18'h0) begin
      errs++;
      $display("FAIL reset_outs got %h want 0",
               {imem_req, imem_addr, instr_valid, halted, pc});
    end
    vecs++;
    if ({opcode, rd, rs1, rs2} !== 16'h0) begin
      errs++;
      $display("FAIL reset_ir got %h want 0000", {opcode, rd, rs1, rs2});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vecs++;
      if (imem_req !== 1'b0 || pc !== 8'h0) begin
        errs++;
        $display("FAIL idle_hold got req=%b pc=%h want 0/00", imem_req, pc);
      end
    end
  endtask

  task automatic test_basic();
    do_reset();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 16'h1123;
    #1;
    vecs++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
      errs++;
      $display("FAIL basic_fetch got req=%b addr=%h want 1/00",
               imem_req, imem_addr);
    end
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 16'h0;
    #1;
    vecs++;
    if (instr_valid !== 1'b1 || {opcode, rd, rs1, rs2} !== 16'h1123) begin
      errs++;
      $display("FAIL basic_exec got iv=%b ir=%h want 1/1123",
               instr_valid, {opcode, rd, rs1, rs2});
    end
    vecs++;
    if (pc !== 8'h01 || imem_req !== 1'b0) begin
      errs++;
      $display("FAIL basic_pc got pc=%h req=%b want 01/0", pc, imem_req);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    imem_ack   = 1'b1;
    imem_rdata = 16'h3210;
    #1;
    vecs++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h01) begin
      errs++;
      $display("FAIL b2b_fetch got req=%b addr=%h want 1/01",
               imem_req, imem_addr);
    end
    @(negedge clk);
    imem_ack = 1'b0;
    #1;
    vecs++;
    if (instr_valid !== 1'b1 || opcode !== 4'h3 || pc !== 8'h02) begin
      errs++;
      $display("FAIL b2b_exec got iv=%b op=%h pc=%h want 1/3/02",
               instr_valid, opcode, pc);
    end
  endtask

  task automatic test_ack_wait();
    logic [15:0] junk [3];
    junk[0] = 16'hF000;
    junk[1] = 16'h0FFF;
    junk[2] = 16'hA5A5;
    do_reset();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        imem_ack   = 1'b0;
        imem_rdata = junk[i];
      end else begin
        imem_ack   = 1'b1;
        imem_rdata = 16'h4567;
      end
      #1;
      vecs++;
      if (imem_req !== 1'b1 || imem_addr !== 8'h00 || opcode !== 4'h0) begin
        errs++;
        $display("FAIL wait_%0d got req=%b addr=%h op=%h want 1/00/0",
                 i, imem_req, imem_addr, opcode);
      end
      @(negedge clk);
    end
    imem_ack   = 1'b0;
    imem_rdata = 16'hFFFF;
    #1;
    vecs++;
    if (instr_valid !== 1'b1 || {opcode, rd, rs1, rs2} !== 16'h4567) begin
      errs++;
      $display("FAIL wait_load got iv=%b ir=%h want 1/4567",
               instr_valid, {opcode, rd, rs1, rs2});
    end
  endtask

  task automatic test_stall();
    @(negedge clk);
    imem_ack   = 1'b1;
    imem_rdata = 16'h2ABC;
    #1;
    vecs++;
    if (imem_addr !== 8'h01) begin
      errs++;
      $display("FAIL stall_addr got %h want 01", imem_addr);
    end
    @(negedge clk);
    imem_ack = 1'b0;
    stall    = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      vecs++;
      if (instr_valid !== 1'b0 || imem_req !== 1'b0 || pc !== 8'h02 ||
          opcode !== 4'h2) begin
        errs++;
        $display("FAIL stall_%0d got iv=%b req=%b pc=%h op=%h want 0/0/02/2",
                 i, instr_valid, imem_req, pc, opcode);
      end
      @(negedge clk);
    end
    stall = 1'b0;
    #1;
    vecs++;
    if (instr_valid !== 1'b1 || rd !== 4'hA) begin
      errs++;
      $display("FAIL stall_release got iv=%b rd=%h want 1/a",
               instr_valid, rd);
    end
  endtask

  task automatic test_halt();
    @(negedge clk);
    imem_ack   = 1'b1;
    imem_rdata = 16'hF000;
    #1;
    vecs++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h02) begin
      errs++;
      $display("FAIL halt_fetch got req=%b addr=%h want 1/02",
               imem_req, imem_addr);
    end
    @(negedge clk);
    imem_ack = 1'b0;
    #1;
    vecs++;
    if (instr_valid !== 1'b0 || opcode !== 4'hF) begin
      errs++;
      $display("FAIL halt_exec got iv=%b op=%h want 0/f", instr_valid, opcode);
    end
    @(negedge clk);
    #1;
    vecs++;
    if (halted !== 1'b1 || pc !== 8'h03 || imem_req !== 1'b0) begin
      errs++;
      $display("FAIL halt_state got h=%b pc=%h req=%b want 1/03/0",
               halted, pc, imem_req);
    end
    start    = 1'b1;
    imem_ack = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    imem_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      vecs++;
      if (halted !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
        errs++;
        $display("FAIL halt_sticky_%0d got h=%b req=%b iv=%b want 1/0/0",
                 i, halted, imem_req, instr_valid);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midfetch();
    do_reset();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 16'h1123;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    #1;
    vecs++;
    if (imem_req !== 1'b1 || pc !== 8'h01) begin
      errs++;
      $display("FAIL mid_pending got req=%b pc=%h want 1/01", imem_req, pc);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vecs++;
    if (imem_req !== 1'b0 || pc !== 8'h00 || halted !== 1'b0 ||
        opcode !== 4'h0) begin
      errs++;
      $display("FAIL mid_reset got req=%b pc=%h h=%b op=%h want 0/00/0/0",
               imem_req, pc, halted, opcode);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    vecs++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
      errs++;
      $display("FAIL mid_refetch got req=%b addr=%h want 1/00",
               imem_req, imem_addr);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] mem [4];
    logic [1:0]  seen [5];
    logic [1:0]  want;
    int          n;
    mem[0] = 16'h1000;
    mem[1] = 16'h2000;
    mem[2] = 16'h3000;
    mem[3] = 16'h4000;
    n = 0;
    do_reset();
    @(negedge clk);
    start2 = 1'b1;
    for (int cyc = 0; cyc < 40 && n < 5; cyc++) begin
      @(negedge clk);
      start2 = 1'b0;
      if (req2) begin
        seen[n] = addr2;
        n++;
        ack2   = 1'b1;
        rdata2 = mem[addr2];
      end else begin
        ack2 = 1'b0;
      end
    end
    ack2 = 1'b0;
    vecs++;
    if (n != 5) begin
      errs++;
      $display("FAIL wrap_timeout got %0d fetches want 5", n);
    end else begin
      for (int i = 0; i < 5; i++) begin
        want = 2'(i % 4);
        vecs++;
        if (seen[i] !== want) begin
          errs++;
          $display("FAIL wrap_addr_%0d got %0d want %0d", i, seen[i], want);
        end
      end
    end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_ack_wait();
    test_stall();
    test_halt();
    test_reset_midfetch();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/instr_fetch_decode.md
INSTR_FETCH_DECODE -- requirements
Module: instr_fetch_decode

Interface
REQ-001 The block SHALL have parameter PC_WIDTH, default 8: program counter and instruction-memory address width.
REQ-002 The block SHALL have parameter INSTR_WIDTH, default 16: instruction word width, fixed at 16 for this ISA.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
REQ-004 clk  in  1  system clock, rising-edge active.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  begin execution from IDLE; sampled on the rising edge.
REQ-007 imem_req  out  1  instruction-memory read request.
REQ-008 imem_addr  out  PC_WIDTH  instruction-memory read address.
REQ-009 imem_rdata  in  INSTR_WIDTH  instruction word; valid only when imem_ack=1.
REQ-010 imem_ack  in  1  read-data-valid acknowledge.
REQ-011 stall  in  1  downstream busy; holds the current instruction.
REQ-012 opcode  out  4  IR[15:12]; drives the control unit.
REQ-013 rd  out  4  IR[11:8], destination register.
REQ-014 rs1  out  4  IR[7:4], source register 1.
REQ-015 rs2  out  4  IR[3:0], source register 2.
REQ-016 instr_valid  out  1  one-cycle execute strobe; fields are valid while high.
REQ-017 pc  out  PC_WIDTH  address of the next instruction to fetch.
REQ-018 halted  out  1  core has stopped on a HALT instruction.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, FETCH, EXEC, HALT.
REQ-020 In IDLE, start=1 SHALL move the FSM to FETCH; start SHALL be ignored in every other state.
REQ-021 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc, both held stable until imem_ack is sampled high.
REQ-022 On the FETCH edge with imem_ack=1, the block SHALL load imem_rdata into IR, set pc to pc+1 modulo 2^PC_WIDTH, and go to EXEC.
REQ-023 imem_ack and imem_rdata SHALL be ignored outside FETCH.
REQ-024 imem_req SHALL be 0 in every state except FETCH.
REQ-025 opcode, rd, rs1 and rs2 SHALL always reflect the current IR and change only when IR loads.
REQ-026 In EXEC with stall=1, instr_valid SHALL be 0 and the FSM SHALL remain in EXEC with IR and pc unchanged.
REQ-027 In EXEC with stall=0 and opcode!=4'b1111, instr_valid SHALL be 1 for that single cycle and the next state SHALL be FETCH.
REQ-028 In EXEC with stall=0 and opcode=4'b1111 (HALT), instr_valid SHALL stay 0 and the next state SHALL be HALT.
REQ-029 Opcodes 4'b0000 and 4'b0101-4'b1110 SHALL be passed through with instr_valid like legal ALU opcodes; the control unit treats them as no-ops.
REQ-030 In HALT, halted SHALL be 1; only rst_n SHALL leave HALT.
REQ-031 Minimum throughput SHALL be one instruction per 2 cycles (FETCH with same-cycle ack, then EXEC).
REQ-032 Latency from start sampled high to instr_valid high SHALL be 2 cycles, plus the ack wait cycles and stall cycles.

Reset
REQ-033 While rst_n=0, regardless of clk, the state SHALL be IDLE and pc, IR, imem_req, imem_addr, instr_valid and halted SHALL all be 0.
REQ-034 Reset asserted mid-FETCH or mid-EXEC SHALL drop imem_req and instr_valid in the same cycle and discard the in-flight instruction.
REQ-035 After rst_n deasserts, the block SHALL remain in IDLE until start is sampled high.

Verification
REQ-036 Start, memory returns 16'h1123 with same-cycle ack -> 2 cycles after start, instr_valid=1 with opcode=1, rd=1, rs1=2, rs2=3, pc=1.
REQ-037 Ack delayed 3 cycles, rdata toggling before ack -> imem_req=1 and imem_addr=0 held for 4 cycles; only the data present with ack is loaded.
REQ-038 stall=1 for 2 EXEC cycles -> instr_valid=0 and no imem_req during the stall; one instr_valid pulse on the first cycle with stall=0.
REQ-039 16'hF000 at address 2 -> no instr_valid for it, halted=1, pc=3, imem_req stays 0 and a later start is ignored.
REQ-040 PC_WIDTH=2 with four non-HALT instructions -> the fifth fetch uses imem_addr=0.
REQ-041 rst_n pulsed low during a pending fetch -> imem_req=0 immediately, pc=0, halted=0; a new start refetches from address 0.
